// File: rtl/hall_call_dispatcher.sv
// -----------------------------------------------------------------------------
// hall_call_dispatcher
//
// Collects hall calls (floor + direction) into per-floor up/down registers,
// walks the pending, unassigned calls with a round-robin pointer and offers
// each one to the closer of two cars over a valid/ready handshake. A call is
// cleared when either car stops at that floor moving in the call's direction.
//
// Ports:
//   clk, reset                       clock (rising edge), async active-low reset
//   request, request_floor/_dir      hall request, sampled every rising edge
//   request_ack / request_err        one-cycle accept / reject pulses
//   current_floor/_dir_elev_N        car position and travel direction
//   idle_elev_N                      car has no pending car calls
//   stop_elev_N                      one-cycle pulse: car doors opened
//   target_valid_elev_N / _ready_    per-car handshake for the offered call
//   target_floor / target_dir        offered call, shared by both cars
//   hall_up_calls / hall_down_calls  pending calls, one bit per floor
//   pending_count                    number of pending entries (both directions)
// -----------------------------------------------------------------------------
module hall_call_dispatcher #(
   parameter int NUM_FLOORS = 7,
   parameter int FLOOR_W    = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  request,
   input  logic [FLOOR_W-1:0]    request_floor,
   input  logic                  request_dir,
   output logic                  request_ack,
   output logic                  request_err,
   input  logic [FLOOR_W-1:0]    current_floor_elev_1,
   input  logic [FLOOR_W-1:0]    current_floor_elev_2,
   input  logic                  current_dir_elev_1,
   input  logic                  current_dir_elev_2,
   input  logic                  idle_elev_1,
   input  logic                  idle_elev_2,
   input  logic                  stop_elev_1,
   input  logic                  stop_elev_2,
   output logic                  target_valid_elev_1,
   input  logic                  target_ready_elev_1,
   output logic                  target_valid_elev_2,
   input  logic                  target_ready_elev_2,
   output logic [FLOOR_W-1:0]    target_floor,
   output logic                  target_dir,
   output logic [NUM_FLOORS-1:0] hall_up_calls,
   output logic [NUM_FLOORS-1:0] hall_down_calls,
   output logic [3:0]            pending_count
);

   localparam int NUM_ENT = 2 * NUM_FLOORS;
   localparam int PTR_W   = $clog2(NUM_ENT);
   localparam int DIST_W  = FLOOR_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_ISSUE
   } state_t;

   // Entry index is {floor, dir}, i.e. floor*2 + dir.
   function automatic logic [PTR_W-1:0] ent_idx(input logic [FLOOR_W-1:0] f,
                                                input logic               d);
      return PTR_W'({f, d});
   endfunction

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(NUM_ENT - 1)) ? '0 : p + 1'b1;
   endfunction

   function automatic logic [DIST_W-1:0] floor_dist(input logic [FLOOR_W-1:0] a,
                                                    input logic [FLOOR_W-1:0] b);
      logic [DIST_W-1:0] ea;
      logic [DIST_W-1:0] eb;
      ea = {1'b0, a};
      eb = {1'b0, b};
      return (ea >= eb) ? (ea - eb) : (eb - ea);
   endfunction

   // Assignment is kept per car: an entry is assigned when either bit is set,
   // and which bit is set records the owning car.
   logic [NUM_ENT-1:0] pend_q, pend_d;
   logic [NUM_ENT-1:0] asg1_q, asg1_d;
   logic [NUM_ENT-1:0] asg2_q, asg2_d;

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [PTR_W-1:0]   cnt_q, cnt_d;       // entries examined in the current lap
   logic [PTR_W-1:0]   tgt_idx_q, tgt_idx_d;
   logic               tgt_car_q, tgt_car_d; // 0 = car 1, 1 = car 2
   logic [FLOOR_W-1:0] tgt_floor_q, tgt_floor_d;
   logic               tgt_dir_q, tgt_dir_d;
   logic               ack_q, ack_d;
   logic               err_q, err_d;
   logic [3:0]         pcount_q, pcount_d;

   logic               req_legal;
   logic [NUM_ENT-1:0] set_vec;
   logic [NUM_ENT-1:0] clr_vec;
   logic [NUM_ENT-1:0] avail;
   logic [FLOOR_W-1:0] scan_floor;
   logic [DIST_W-1:0]  d1, d2;
   logic               win_car;
   logic               handshake;

   // ---------------------------------------------------------------------------
   // Request decode and service clear
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every combinational output gets a default before any branch, so no
      // path leaves a variable unassigned and no latch is inferred.
      req_legal = (32'(request_floor) < NUM_FLOORS)
               && !( request_dir && (32'(request_floor) == NUM_FLOORS - 1))
               && !(!request_dir && (request_floor == '0));
      ack_d   = request &&  req_legal;
      err_d   = request && !req_legal;
      set_vec = '0;
      if (ack_d) set_vec[ent_idx(request_floor, request_dir)] = 1'b1;

      // Both stops on the same entry simply set the same bit.
      clr_vec = '0;
      if (stop_elev_1 && (32'(current_floor_elev_1) < NUM_FLOORS))
         clr_vec[ent_idx(current_floor_elev_1, current_dir_elev_1)] = 1'b1;
      if (stop_elev_2 && (32'(current_floor_elev_2) < NUM_FLOORS))
         clr_vec[ent_idx(current_floor_elev_2, current_dir_elev_2)] = 1'b1;
   end

   // ---------------------------------------------------------------------------
   // Car selection for the entry under the scan pointer
   // ---------------------------------------------------------------------------
   always_comb begin
      // An entry being cleared this cycle is not worth offering.
      avail      = pend_q & ~(asg1_q | asg2_q) & ~clr_vec;
      scan_floor = FLOOR_W'(ptr_q >> 1);
      d1         = floor_dist(scan_floor, current_floor_elev_1);
      d2         = floor_dist(scan_floor, current_floor_elev_2);
      if (d1 < d2)                          win_car = 1'b0;
      else if (d2 < d1)                     win_car = 1'b1;
      else if (idle_elev_2 && !idle_elev_1) win_car = 1'b1;
      else                                  win_car = 1'b0;
      handshake = tgt_car_q ? target_ready_elev_2 : target_ready_elev_1;
   end

   // ---------------------------------------------------------------------------
   // FSM next state and call-storage update
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      tgt_idx_d   = tgt_idx_q;
      tgt_car_d   = tgt_car_q;
      tgt_floor_d = tgt_floor_q;
      tgt_dir_d   = tgt_dir_q;
      // Clear wins over a same-cycle request for the same entry.
      pend_d      = (pend_q | set_vec) & ~clr_vec;
      asg1_d      = asg1_q & ~clr_vec;
      asg2_d      = asg2_q & ~clr_vec;

      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (|(pend_q & ~(asg1_q | asg2_q))) state_d = ST_SCAN;
         end
         ST_SCAN: begin
            ptr_d = ptr_inc(ptr_q);
            if (avail[ptr_q]) begin
               tgt_idx_d   = ptr_q;
               tgt_car_d   = win_car;
               tgt_floor_d = scan_floor;
               tgt_dir_d   = ptr_q[0];
               state_d     = ST_ISSUE;
            end else if (cnt_q == PTR_W'(NUM_ENT - 1)) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_ISSUE: begin
            if (clr_vec[tgt_idx_q]) begin
               // Serviced while on offer: withdraw without a transfer.
               state_d = ST_SCAN;
               cnt_d   = '0;
            end else if (handshake) begin
               if (tgt_car_q) asg2_d[tgt_idx_q] = 1'b1;
               else           asg1_d[tgt_idx_q] = 1'b1;
               state_d = ST_SCAN;
               cnt_d   = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      pcount_d = '0;
      for (int i = 0; i < NUM_ENT; i++) pcount_d = pcount_d + 4'(pend_d[i]);
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: the call table is a handful of flops, not a RAM, so it is reset
         // with everything else; stale calls after reset would be dispatched.
         pend_q      <= '0;
         asg1_q      <= '0;
         asg2_q      <= '0;
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         cnt_q       <= '0;
         tgt_idx_q   <= '0;
         tgt_car_q   <= 1'b0;
         tgt_floor_q <= '0;
         tgt_dir_q   <= 1'b0;
         ack_q       <= 1'b0;
         err_q       <= 1'b0;
         pcount_q    <= '0;
      end else begin
         // NOTE: non-blocking assignments here so every register samples the
         // pre-edge values regardless of statement order.
         pend_q      <= pend_d;
         asg1_q      <= asg1_d;
         asg2_q      <= asg2_d;
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         tgt_idx_q   <= tgt_idx_d;
         tgt_car_q   <= tgt_car_d;
         tgt_floor_q <= tgt_floor_d;
         tgt_dir_q   <= tgt_dir_d;
         ack_q       <= ack_d;
         err_q       <= err_d;
         pcount_q    <= pcount_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign request_ack         = ack_q;
   assign request_err         = err_q;
   assign target_valid_elev_1 = (state_q == ST_ISSUE) && !tgt_car_q;
   assign target_valid_elev_2 = (state_q == ST_ISSUE) &&  tgt_car_q;
   assign target_floor        = tgt_floor_q;
   assign target_dir          = tgt_dir_q;
   assign pending_count       = pcount_q;

   for (genvar f = 0; f < NUM_FLOORS; f++) begin : g_hall
      assign hall_up_calls[f]   = pend_q[2*f+1];
      assign hall_down_calls[f] = pend_q[2*f];
   end

endmodule
